// File: rtl/counter_btn_ctrl.sv
// Run/stop/clear/mode control for the up/down counter, with prescaled tick and status-byte TX buffer.
// Define CTRL_AUTOSTOP_EN to saturate and stop at the count limits instead of wrapping.
module counter_btn_ctrl #(
  parameter  int TICK_DIV = 100_000,
  parameter  int CNT_MAX  = 9999,
  localparam int CW       = $clog2(CNT_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_btn_run,
  input  logic          i_btn_clear,
  input  logic          i_btn_mode,
  output logic [CW-1:0] o_count,
  output logic          o_run,
  output logic          o_dir,
  output logic          o_cnt_tick,
  output logic          o_cnt_clear,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_tx_drop
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_presc;
  logic            r_dir;
  logic            r_run;
  logic            r_cnt_tick;
  logic            r_cnt_clear;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic            r_tx_drop;

  state_t          w_state_next;
  logic [CW-1:0]   w_count_next;
  logic [CW-1:0]   w_stepped;
  logic [PW-1:0]   w_presc_next;
  logic            w_dir_next;
  logic            w_step;
  logic            w_tx_load;
  logic            w_clr_evt;

  // Step always uses the pre-command direction.
  assign w_stepped = r_dir ? ((r_count == '0) ? CW'(CNT_MAX) : r_count - CW'(1))
                           : ((r_count == CW'(CNT_MAX)) ? '0 : r_count + CW'(1));

`ifdef CTRL_AUTOSTOP_EN
  logic w_wrap;
  assign w_wrap = r_dir ? (r_count == '0) : (r_count == CW'(CNT_MAX));
`endif

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_presc_next = r_presc;
    w_dir_next   = r_dir;
    w_step       = 1'b0;
    w_tx_load    = 1'b0;
    w_clr_evt    = 1'b0;
    case (r_state)
      ST_CLEAR: w_state_next = ST_STOP;
      default: begin
        if (i_btn_clear) begin
          w_state_next = ST_CLEAR;
          w_count_next = '0;
          w_presc_next = '0;
          w_tx_load    = 1'b1;
          w_clr_evt    = 1'b1;
        end else begin
          if (i_btn_run) begin
            w_tx_load    = 1'b1;
            w_state_next = (r_state == ST_RUN) ? ST_STOP : ST_RUN;
          end else if (i_btn_mode) begin
            w_tx_load  = 1'b1;
            w_dir_next = ~r_dir;
          end
          // A run/stop command freezes the prescaler in its current phase.
          if (r_state == ST_RUN && !i_btn_run) begin
            if (r_presc == PW'(TICK_DIV - 1)) begin
              w_step       = 1'b1;
              w_presc_next = '0;
`ifdef CTRL_AUTOSTOP_EN
              if (w_wrap) begin
                w_state_next = ST_STOP;
                w_tx_load    = 1'b1;
              end else begin
                w_count_next = w_stepped;
              end
`else
              w_count_next = w_stepped;
`endif
            end else begin
              w_presc_next = r_presc + PW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_STOP;
      r_count     <= '0;
      r_presc     <= '0;
      r_dir       <= 1'b0;
      r_run       <= 1'b0;
      r_cnt_tick  <= 1'b0;
      r_cnt_clear <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_drop   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_presc     <= w_presc_next;
      r_dir       <= w_dir_next;
      r_run       <= (w_state_next == ST_RUN);
      r_cnt_tick  <= w_step;
      r_cnt_clear <= (w_state_next == ST_CLEAR);
      r_tx_drop   <= 1'b0;
      if (w_tx_load) begin
        r_tx_data  <= {4'hA, 1'b0, (w_state_next == ST_RUN), w_dir_next, w_clr_evt};
        r_tx_valid <= 1'b1;
        r_tx_drop  <= r_tx_valid & ~i_tx_ready;
      end else if (r_tx_valid && i_tx_ready) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign o_count     = r_count;
  assign o_run       = r_run;
  assign o_dir       = r_dir;
  assign o_cnt_tick  = r_cnt_tick;
  assign o_cnt_clear = r_cnt_clear;
  assign o_tx_data   = r_tx_data;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_drop   = r_tx_drop;

endmodule

// File: doc/counter_btn_ctrl.md
Name: counter_btn_ctrl

Overview:
Control FSM between the debounced button pulses and the up/down counter datapath. It takes single-cycle button events for run/stop, clear and mode. It sequences the counter through STOP/RUN/CLEAR, generates the prescaled count tick, and holds the count value. On every accepted command it sends a status byte to the SPI transmit path over a valid/ready handshake.

Parameters:
TICK_DIV, 100_000, clk cycles per count step while running (>=2)
CNT_MAX, 9999, maximum count value; count range is 0..CNT_MAX
CW, $clog2(CNT_MAX+1), count width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
i_btn_run  input  1  1-cycle pulse: toggle run/stop
i_btn_clear  input  1  1-cycle pulse: clear count and stop
i_btn_mode  input  1  1-cycle pulse: toggle count direction
o_count  output  CW  current count value
o_run  output  1  1 = RUN state
o_dir  output  1  0 = up, 1 = down
o_cnt_tick  output  1  1-cycle pulse on each count step
o_cnt_clear  output  1  1-cycle pulse in CLEAR state
o_tx_data  output  8  status byte {4'hA, 1'b0, run, dir, clr_evt}
o_tx_valid  output  1  status byte available
i_tx_ready  input  1  downstream accepts byte when valid & ready
o_tx_drop  output  1  1-cycle pulse when a pending unsent byte is overwritten

Behaviour:
- Reset (reset==0 at clk edge): state=STOP, count=0, prescaler=0, dir=0. All outputs 0, including o_tx_data=8'h00 and o_tx_valid=0. Reset overrides every other input in the same cycle, including mid-handshake; the pending byte is discarded.
- States:
  - STOP: o_run=0.
  - RUN: o_run=1.
  - CLEAR: transient, exactly 1 cycle.
- Simultaneous button pulses, priority clear > run > mode. Exactly one command is accepted per cycle; lower-priority pulses in that cycle are ignored.
- STOP transitions:
  - run -> RUN
  - clear -> CLEAR
  - mode -> dir toggles, stay STOP
- RUN transitions:
  - run -> STOP
  - clear -> CLEAR
  - mode -> dir toggles, stay RUN
- CLEAR: o_cnt_clear=1, count<=0, prescaler<=0, next state STOP unconditionally. Button pulses during CLEAR are ignored.
- Latency: all outputs are registered. A pulse at edge N is reflected in o_run, o_dir and o_tx_valid after edge N+1.
- Prescaler: increments only in RUN and freezes in STOP (pause/resume keeps phase). When the prescaler is at TICK_DIV-1 in RUN:
  - prescaler<=0 and o_cnt_tick=1 for one cycle;
  - count steps: up does CNT_MAX->0 wrap, down does 0->CNT_MAX wrap.
- A clear command in the same cycle as a tick: clear wins, no step, no tick.
- A run-stop command in the same cycle as a tick: the step is suppressed and the prescaler holds TICK_DIV-1.
- A mode toggle in the same cycle as a tick: the step uses the old dir.
- TX path, one-entry buffer:
  - Each accepted command loads o_tx_data with the post-command state: run and dir are the new values, clr_evt=1 only for clear. o_tx_valid is set.
  - o_tx_data is stable while valid & !ready.
  - A byte transfers on valid & ready; valid drops next cycle unless a new command loads in that same cycle. In that case the new byte replaces it and valid stays 1, with no drop.
  - A new command while valid & !ready overwrites the byte with the newest status and pulses o_tx_drop.
- Count ticks alone never generate TX bytes.

Optional Feature:
CTRL_AUTOSTOP_EN.
- Defined: in RUN, a step that would wrap instead saturates and stops the counter.
  - Up from CNT_MAX, or down from 0: count holds, state becomes STOP, o_cnt_tick still pulses.
  - A status byte {4'hA,0,0,dir,0} is queued under the normal TX rules.
- Undefined: wrap-around as in Behaviour, with no auto-generated TX byte.

Test Plan:
- Reset/run: TICK_DIV=4, CNT_MAX=9; run pulse at cycle 10 -> o_run=1 at 11, o_tx_data=8'hA4 with valid held until ready. After 12 clocks, count=3 and o_cnt_tick has pulsed every 4 cycles.
- Up wrap: count=9, dir=0, tick -> count=0. Mode pulse, then next tick -> count=9 (down wrap), o_dir=1, TX byte 8'hA6.
- Priority: clear+run+mode in the same cycle while RUN with count=5 -> CLEAR one cycle, o_cnt_clear=1, then STOP, count=0, dir unchanged, TX byte 8'hA1 (dir=0).
- TX backpressure: i_tx_ready=0; run, then mode two cycles later -> o_tx_drop pulses once, o_tx_data=8'hA6. Ready=1 -> one transfer, valid falls next cycle.
- Pause/reset: stop at prescaler=2, wait 20 cycles, run -> first tick 2 cycles later, not 4. Drive reset=0 during valid & !ready -> all outputs 0 after the edge.
- CTRL_AUTOSTOP_EN defined: count=9, up, running -> at tick count stays 9, o_run=0, TX byte 8'hA0. Without the macro -> count=0, o_run=1.
